// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad entry block.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        ACT      = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    localparam logic [3:0] KEY_CLEAR = 4'd14;
    localparam logic [3:0] KEY_ENTER = 4'd15;
    localparam int         DIGIT_W   = 4;

    // Index of the lowest set bit; used for both row priority and the one-hot column.
    function automatic logic [1:0] lowest_set(input logic [3:0] v);
        if (v[0])      return 2'd0;
        else if (v[1]) return 2'd1;
        else if (v[2]) return 2'd2;
        else           return 2'd3;
    endfunction

endpackage

// File: rtl/bcd2_to_bin.sv
// Two decimal digits (tens, units) to an 8-bit binary value 0..99.
module bcd2_to_bin
    import keypad_pkg::*;
(
    input  logic [DIGIT_W-1:0] tens,
    input  logic [DIGIT_W-1:0] units,
    output logic [7:0]         bin
);

    assign bin = (8'(tens) << 3) + (8'(tens) << 1) + 8'(units);

endmodule

// File: rtl/keypad_entry.sv
// 4x4 keypad scanner with debounce that assembles up to four digits into a 16-bit value.
// Optional live-entry output ECHO is enabled by defining KEY_ECHO_EN.
module keypad_entry
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 20000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  ROW,
    output logic [3:0]  COL,
    output logic [15:0] A,
    output logic        valid,
    output logic [2:0]  ndig
`ifdef KEY_ECHO_EN
    ,
    output logic [15:0] ECHO
`endif
);

    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DEB_W  = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CNT - 1);

    state_t                        state_q, state_d;
    logic [3:0]                    col_q, col_d;
    logic [1:0]                    row_idx_q, row_idx_d;
    logic [SCAN_W-1:0]             scan_cnt_q, scan_cnt_d;
    logic [DEB_W-1:0]              deb_cnt_q, deb_cnt_d;
    logic [3:0][DIGIT_W-1:0]       dig_q, dig_d;
    logic [2:0]                    ndig_q, ndig_d;
    logic [15:0]                   a_q, a_d;
    logic                          valid_q, valid_d;
    logic [15:0]                   a_bin;
    logic [3:0]                    key_code;

    assign key_code = {lowest_set(col_q), row_idx_q};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_a_conv
            bcd2_to_bin u_conv (
                .tens  (dig_q[2*gi+1]),
                .units (dig_q[2*gi]),
                .bin   (a_bin[8*gi +: 8])
            );
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        row_idx_d  = row_idx_q;
        scan_cnt_d = scan_cnt_q;
        deb_cnt_d  = deb_cnt_q;
        dig_d      = dig_q;
        ndig_d     = ndig_q;
        a_d        = a_q;
        valid_d    = 1'b0;
        case (state_q)
            SCAN: begin
                if (scan_cnt_q == SCAN_LAST) begin
                    scan_cnt_d = '0;
                    if (ROW != 4'b0000) begin
                        row_idx_d = lowest_set(ROW);
                        state_d   = DEBOUNCE;
                    end else begin
                        col_d = {col_q[2:0], col_q[3]};
                    end
                end else begin
                    scan_cnt_d = scan_cnt_q + 1'b1;
                end
            end
            DEBOUNCE: begin
                // A dropout sends us back to rescan the same column from a fresh dwell.
                if (!ROW[row_idx_q]) begin
                    deb_cnt_d = '0;
                    state_d   = SCAN;
                end else if (deb_cnt_q == DEB_LAST) begin
                    deb_cnt_d = '0;
                    state_d   = ACT;
                end else begin
                    deb_cnt_d = deb_cnt_q + 1'b1;
                end
            end
            ACT: begin
                state_d = RELEASE;
                if (key_code < 4'd10) begin
                    if (ndig_q < 3'd4) begin
                        dig_d  = {dig_q[2:0], key_code};
                        ndig_d = ndig_q + 3'd1;
                    end
                end else if (key_code == KEY_CLEAR) begin
                    dig_d  = '0;
                    ndig_d = 3'd0;
                end else if (key_code == KEY_ENTER) begin
                    a_d     = a_bin;
                    valid_d = 1'b1;
                    dig_d   = '0;
                    ndig_d  = 3'd0;
                end
            end
            RELEASE: begin
                if (ROW != 4'b0000) begin
                    deb_cnt_d = '0;
                end else if (deb_cnt_q == DEB_LAST) begin
                    deb_cnt_d = '0;
                    state_d   = SCAN;
                    col_d     = {col_q[2:0], col_q[3]};
                end else begin
                    deb_cnt_d = deb_cnt_q + 1'b1;
                end
            end
            default: state_d = SCAN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= SCAN;
            col_q      <= 4'b0001;
            row_idx_q  <= 2'd0;
            scan_cnt_q <= '0;
            deb_cnt_q  <= '0;
            dig_q      <= '0;
            ndig_q     <= 3'd0;
            a_q        <= 16'd0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            row_idx_q  <= row_idx_d;
            scan_cnt_q <= scan_cnt_d;
            deb_cnt_q  <= deb_cnt_d;
            dig_q      <= dig_d;
            ndig_q     <= ndig_d;
            a_q        <= a_d;
            valid_q    <= valid_d;
        end
    end

    assign COL   = col_q;
    assign A     = a_q;
    assign valid = valid_q;
    assign ndig  = ndig_q;

`ifdef KEY_ECHO_EN
    logic [15:0] echo_q, echo_d;
    logic [15:0] echo_bin;

    generate
        for (gi = 0; gi < 2; gi++) begin : g_echo_conv
            bcd2_to_bin u_conv (
                .tens  (dig_d[2*gi+1]),
                .units (dig_d[2*gi]),
                .bin   (echo_bin[8*gi +: 8])
            );
        end
    endgenerate

    always_comb begin
        echo_d = echo_q;
        if (state_q == ACT) echo_d = echo_bin;
    end

    always_ff @(posedge clk) begin
        if (rst) echo_q <= 16'd0;
        else     echo_q <= echo_d;
    end

    assign ECHO = echo_q;
`endif

endmodule

// File: tb/tb_keypad_entry.sv
// Bench for keypad_entry: behavioural keypad model, digit-buffer model and a scoreboard of committed values.
module tb_keypad_entry;

    localparam int SCAN_DIV     = 4;
    localparam int DEBOUNCE_CNT = 8;
    localparam int HOLD         = 40;
    localparam int REL          = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [15:0] a_out;
    logic        valid;
    logic [2:0]  ndig;
`ifdef KEY_ECHO_EN
    logic [15:0] echo;
`endif

    logic       key_on  = 1'b0;
    logic [3:0] key_sel = 4'd0;

    int passes = 0;
    int total  = 0;
    int vcount = 0;
    logic valid_prev = 1'b0;

    logic [15:0] exp_q[$];
    int          mdig[4];
    int          mn;
    logic [15:0] ma;

    always #5 clk = ~clk;

    // The pressed key closes its row only while its column is strobed.
    assign row = (key_on && col[key_sel[3:2]]) ? (4'b0001 << key_sel[1:0]) : 4'b0000;

    keypad_entry #(
        .SCAN_DIV     (SCAN_DIV),
        .DEBOUNCE_CNT (DEBOUNCE_CNT)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .ROW   (row),
        .COL   (col),
        .A     (a_out),
        .valid (valid),
        .ndig  (ndig)
`ifdef KEY_ECHO_EN
        ,
        .ECHO  (echo)
`endif
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp)
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        else
            passes++;
    endtask

    always @(negedge clk) begin
        if (valid) begin
            vcount++;
            check("valid_one_cycle", {15'd0, valid_prev}, 16'd0);
            if (exp_q.size() == 0) begin
                check("valid_unexpected", 16'd1, 16'd0);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                $display("enter: A=%h expected %h", a_out, e);
                check("A_commit", a_out, e);
            end
        end
        valid_prev = valid;
    end

    function automatic logic [15:0] model_value();
        logic [7:0] hi, lo;
        hi = 8'(mdig[3] * 10 + mdig[2]);
        lo = 8'(mdig[1] * 10 + mdig[0]);
        return {hi, lo};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 4; i++) mdig[i] = 0;
        mn = 0;
    endtask

    task automatic model_key(input int k);
        if (k < 10) begin
            if (mn < 4) begin
                mdig[3] = mdig[2]; mdig[2] = mdig[1]; mdig[1] = mdig[0]; mdig[0] = k;
                mn++;
            end
        end else if (k == 14) begin
            model_clear();
        end else if (k == 15) begin
            ma = model_value();
            exp_q.push_back(ma);
            model_clear();
        end
    endtask

    task automatic press(input int k);
        int v0;
        v0 = vcount;
        model_key(k);
        key_sel = 4'(k);
        key_on  = 1'b1;
        repeat (HOLD) @(negedge clk);
        key_on = 1'b0;
        repeat (REL) @(negedge clk);
        $display("key %0d: ndig=%0d A=%h", k, ndig, a_out);
        check("ndig", {13'd0, ndig}, 16'(mn));
        check("A_now", a_out, ma);
        check("valid_count", 16'(vcount - v0), (k == 15) ? 16'd1 : 16'd0);
    endtask

    task automatic wait_col(input logic [3:0] c);
        int n;
        n = 0;
        while (col !== c && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (col !== c) check("wait_col_timeout", {12'd0, col}, {12'd0, c});
    endtask

    initial begin
        int v0;
        model_clear();
        ma = 16'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_col", {12'd0, col}, 16'h0001);
        check("reset_A", a_out, 16'h0000);
        check("reset_valid", {15'd0, valid}, 16'd0);
        check("reset_ndig", {13'd0, ndig}, 16'd0);

        press(1); press(2); press(3); press(4); press(15);
        check("A_1234", a_out, 16'h0C22);

        press(9); press(8); press(7); press(6); press(5); press(15);
        check("A_98765", a_out, 16'h624C);

        press(5); press(14);
        check("A_after_clear", a_out, 16'h624C);
        press(7); press(15);
        check("A_7", a_out, 16'h0007);

        // Short press on key 3 (column 0) aligned to the start of the column-0 dwell.
        v0 = vcount;
        wait_col(4'b1000);
        wait_col(4'b0001);
        key_sel = 4'd3;
        key_on  = 1'b1;
        repeat (5) @(negedge clk);
        key_on = 1'b0;
        repeat (3) @(negedge clk);
        check("short_same_col", {12'd0, col}, 16'h0001);
        repeat (2) @(negedge clk);
        check("short_next_col", {12'd0, col}, 16'h0002);
        repeat (30) @(negedge clk);
        check("short_ndig", {13'd0, ndig}, 16'(mn));
        check("short_no_valid", 16'(vcount - v0), 16'd0);

        // Long hold of key 2 followed by a bouncy release.
        v0 = vcount;
        model_key(2);
        key_sel = 4'd2;
        key_on  = 1'b1;
        repeat (200) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            key_on = ~key_on;
            repeat (3) @(negedge clk);
        end
        key_on = 1'b0;
        repeat (30) @(negedge clk);
        $display("hold key 2: ndig=%0d", ndig);
        check("hold_ndig", {13'd0, ndig}, 16'd1);
        check("hold_no_valid", 16'(vcount - v0), 16'd0);
        press(15);
        check("A_2", a_out, 16'h0002);

        press(0); press(1); press(0); press(2); press(15);
        check("A_0102", a_out, 16'h0102);

        // Reset while debouncing key 5 (column 1).
        wait_col(4'b0001);
        key_sel = 4'd5;
        key_on  = 1'b1;
        wait_col(4'b0010);
        repeat (SCAN_DIV + 3) @(negedge clk);
        check("pre_rst_frozen", {12'd0, col}, 16'h0002);
        rst = 1'b1;
        @(negedge clk);
        $display("reset mid-debounce: COL=%b A=%h ndig=%0d", col, a_out, ndig);
        check("rst_col", {12'd0, col}, 16'h0001);
        check("rst_A", a_out, 16'h0000);
        check("rst_ndig", {13'd0, ndig}, 16'd0);
        check("rst_valid", {15'd0, valid}, 16'd0);
        rst    = 1'b0;
        key_on = 1'b0;
        repeat (30) @(negedge clk);
        check("scoreboard_empty", 16'(exp_q.size()), 16'd0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
